// File: rtl/control_captura_pkg.sv
// Shared types for the OV7670 capture path: FSM encoding and RGB565->RGB332 field positions.
package control_captura_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_SYNC    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  // First camera byte carries R[7:5] and the top of G; second byte carries the B field used.
  localparam int R_HI = 7;
  localparam int R_LO = 5;
  localparam int G_HI = 2;
  localparam int G_LO = 0;
  localparam int B_HI = 4;
  localparam int B_LO = 3;

  function automatic logic [7:0] rgb565_to_332(input logic [7:0] b1, input logic [7:0] b2);
    return {b1[R_HI:R_LO], b1[G_HI:G_LO], b2[B_HI:B_LO]};
  endfunction

endpackage

// File: rtl/control_captura_pix.sv
// Byte-pair assembler: latches the first byte, presents an RGB332 pixel combinationally with the second.
// Zero latency to pix_vld; no backpressure (camera bytes cannot be stalled).
module control_captura_pix
  import control_captura_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] datos,
  output logic       pix_vld,
  output logic [7:0] pix_dat
);

  logic       phase_q, phase_d;
  logic [7:0] b1_q, b1_d;

  always_comb begin
    phase_d = phase_q;
    b1_d    = b1_q;
    if (clr) begin
      phase_d = 1'b0;
    end else if (en) begin
      phase_d = ~phase_q;
      if (!phase_q) b1_d = datos;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= 1'b0;
      b1_q    <= '0;
    end else begin
      phase_q <= phase_d;
      b1_q    <= b1_d;
    end
  end

  assign pix_vld = en & phase_q & ~clr;
  assign pix_dat = rgb565_to_332(b1_q, datos);

endmodule

// File: rtl/control_captura.sv
// Frame-capture FSM: aligns to VSYNC/HREF, decimates, and writes RGB332 pixels to the DP RAM.
// RAM write registered one PCLK after the second byte; no backpressure, overflow flagged when RAM is full.
module control_captura
  import control_captura_pkg::*;
#(
  parameter int IN_W = 640,
  parameter int IN_H = 480,
  parameter int DEC  = 4,
  parameter int AW   = 15
) (
  input  logic          PCLK,
  input  logic          rst,
  input  logic          start,
  input  logic          continuous,
  input  logic          VSYNC,
  input  logic          HREF,
  input  logic [7:0]    datos,
  output logic [7:0]    DP_RAM_data_in,
  output logic [AW-1:0] DP_RAM_addr_in,
  output logic          regW,
  output logic          busy,
  output logic          frame_done,
  output logic          overflow
);

  localparam int XW    = $clog2(IN_W + 1);
  localparam int YW    = $clog2(IN_H + 1);
  localparam int DEPTH = (IN_W / DEC) * (IN_H / DEC);
  // Writes stop at whichever is smaller: the decimated frame or the RAM.
  localparam int LIMIT = (DEPTH < (1 << AW)) ? DEPTH : (1 << AW);

  state_e        state_q, state_d;
  logic          vsync_q, href_q;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic          full_q, full_d;
  logic          ovf_q, ovf_d;
  logic          regw_q, regw_d;
  logic [7:0]    data_q, data_d;
  logic [AW-1:0] addr_q, addr_d;

  logic       pix_clr, pix_en, pix_vld;
  logic [7:0] pix_dat;
  logic       vsync_fall, vsync_rise, href_fall, keep;

  assign vsync_fall = vsync_q & ~VSYNC;
  assign vsync_rise = ~vsync_q & VSYNC;
  assign href_fall  = href_q & ~HREF;
  assign pix_en     = (state_q == ST_CAPTURE) & HREF;
  assign keep       = ((x_q & XW'(DEC - 1)) == '0) && ((y_q & YW'(DEC - 1)) == '0) &&
                      (x_q < XW'(IN_W)) && (y_q < YW'(IN_H));

  control_captura_pix u_pix (
    .clk     (PCLK),
    .rst_n   (rst),
    .clr     (pix_clr),
    .en      (pix_en),
    .datos   (datos),
    .pix_vld (pix_vld),
    .pix_dat (pix_dat)
  );

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    waddr_d = waddr_q;
    full_d  = full_q;
    ovf_d   = ovf_q;
    regw_d  = 1'b0;
    data_d  = data_q;
    addr_d  = addr_q;
    pix_clr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ARM;
          ovf_d   = 1'b0;
        end
      end
      ST_ARM: begin
        if (VSYNC) state_d = ST_SYNC;
      end
      ST_SYNC: begin
        if (vsync_fall) begin
          state_d = ST_CAPTURE;
          x_d     = '0;
          y_d     = '0;
          waddr_d = '0;
          full_d  = 1'b0;
          pix_clr = 1'b1;
        end
      end
      ST_CAPTURE: begin
        if (vsync_rise) begin
          state_d = ST_DONE;
        end else if (href_fall) begin
          // Line end also drops any unpaired first byte.
          x_d     = '0;
          y_d     = (y_q == YW'(IN_H)) ? y_q : y_q + YW'(1);
          pix_clr = 1'b1;
        end else if (pix_vld) begin
          x_d = (x_q == XW'(IN_W)) ? x_q : x_q + XW'(1);
          if (keep) begin
            if (full_q) begin
              ovf_d = 1'b1;
            end else begin
              regw_d = 1'b1;
              data_d = pix_dat;
              addr_d = waddr_q;
              if (waddr_q == AW'(LIMIT - 1)) full_d = 1'b1;
              else waddr_d = waddr_q + AW'(1);
            end
          end
        end
      end
      ST_DONE: begin
        state_d = continuous ? ST_SYNC : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      waddr_q <= '0;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
      regw_q  <= 1'b0;
      data_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      vsync_q <= VSYNC;
      href_q  <= HREF;
      x_q     <= x_d;
      y_q     <= y_d;
      waddr_q <= waddr_d;
      full_q  <= full_d;
      ovf_q   <= ovf_d;
      regw_q  <= regw_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
    end
  end

  assign DP_RAM_data_in = data_q;
  assign DP_RAM_addr_in = addr_q;
  assign regW           = regw_q;
  assign overflow       = ovf_q;
  assign busy           = (state_q != ST_IDLE);
  assign frame_done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_control_captura.sv
// Scoreboard bench: stimulus pushes expected RAM writes, a negedge monitor pops and compares them.
module tb_control_captura;

  localparam int IN_W = 8;
  localparam int IN_H = 4;
  localparam int DEC  = 2;
  localparam int AW   = 4;

  logic PCLK, rst, start, continuous, VSYNC, HREF;
  logic [7:0] datos;
  logic [7:0] d_data;  logic [AW-1:0] d_addr;  logic d_regw, d_busy, d_fd, d_ovf;
  logic [7:0] d1_data; logic [AW-1:0] d1_addr; logic d1_regw, d1_busy, d1_fd, d1_ovf;

  control_captura #(.IN_W(IN_W), .IN_H(IN_H), .DEC(DEC), .AW(AW)) dut (
    .PCLK(PCLK), .rst(rst), .start(start), .continuous(continuous), .VSYNC(VSYNC),
    .HREF(HREF), .datos(datos), .DP_RAM_data_in(d_data), .DP_RAM_addr_in(d_addr),
    .regW(d_regw), .busy(d_busy), .frame_done(d_fd), .overflow(d_ovf));

  // Same camera stream without decimation: 32 pixels into a 16-entry RAM.
  control_captura #(.IN_W(IN_W), .IN_H(IN_H), .DEC(1), .AW(AW)) dut1 (
    .PCLK(PCLK), .rst(rst), .start(start), .continuous(continuous), .VSYNC(VSYNC),
    .HREF(HREF), .datos(datos), .DP_RAM_data_in(d1_data), .DP_RAM_addr_in(d1_addr),
    .regW(d1_regw), .busy(d1_busy), .frame_done(d1_fd), .overflow(d1_ovf));

  typedef struct packed { logic [7:0] d; logic [AW-1:0] a; } exp_t;
  exp_t exp_q[$];

  int n_chk = 0, n_fail = 0;
  int wr_cnt = 0, fd_cnt = 0, wr1_cnt = 0;
  logic [AW-1:0] last_addr1 = '0;
  int m_y, m_addr;

  // Hand-computed RGB565 byte pairs and their RGB332 pixels.
  logic [7:0] tbl_b1 [4] = '{8'hE0, 8'h1F, 8'hA5, 8'h48};
  logic [7:0] tbl_b2 [4] = '{8'h18, 8'hFF, 8'h5A, 8'h10};
  logic [7:0] tbl_px [4] = '{8'hE3, 8'h1F, 8'hB7, 8'h42};

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge PCLK) begin
    if (d_regw === 1'b1) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_write: got data %0h addr %0h, none expected", d_data, d_addr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wr_data", d_data, e.d);
        chk("wr_addr", d_addr, e.a);
      end
    end
    if (d_fd === 1'b1) fd_cnt++;
    if (d1_regw === 1'b1) begin
      wr1_cnt++;
      last_addr1 = d1_addr;
    end
  end

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick();
    start = 1'b0; tick(); tick();
  endtask

  task automatic drive_line(input int nbytes, input int mode, input bit exp);
    int x, idx;
    HREF = 1'b1;
    for (int i = 0; i < nbytes; i++) begin
      x   = i / 2;
      idx = (mode == 0) ? 0 : ((x / 2 + m_y) % 4);
      datos = (i % 2 == 0) ? tbl_b1[idx] : tbl_b2[idx];
      if ((i % 2 == 1) && exp && (x % DEC == 0) && (m_y % DEC == 0) &&
          (x < IN_W) && (m_y < IN_H) && (m_addr < 8)) begin
        exp_q.push_back({tbl_px[idx], AW'(m_addr)});
        m_addr++;
      end
      tick();
    end
    HREF = 1'b0; datos = 8'h00;
    tick(); tick(); tick();
    m_y++;
  endtask

  // Enters and leaves with VSYNC high.
  task automatic send_frame(input int nlines, input int first_bytes, input int mode,
                            input bit exp, input bit drop_cont);
    m_y = 0; m_addr = 0;
    VSYNC = 1'b0; tick(); tick();
    for (int l = 0; l < nlines; l++) begin
      drive_line((l == 0) ? first_bytes : 16, mode, exp);
      if (drop_cont && l == 0) continuous = 1'b0;
    end
    VSYNC = 1'b1;
    repeat (5) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int fd0, wr0, w10;
    rst = 1'b0; start = 1'b0; continuous = 1'b0; VSYNC = 1'b1; HREF = 1'b0; datos = 8'h00;
    m_y = 0; m_addr = 0;
    #3;
    chk("rst_data", d_data, 8'h00);
    chk("rst_addr", d_addr, 0);
    chk("rst_regw", d_regw, 0);
    chk("rst_busy", d_busy, 0);
    chk("rst_fd",   d_fd, 0);
    chk("rst_ovf",  d_ovf, 0);
    tick(); tick();
    rst = 1'b1;
    tick();

    // Single frame, constant pixel; DEC=1 instance overflows the 16-entry RAM.
    fd0 = fd_cnt; wr0 = wr_cnt; w10 = wr1_cnt;
    pulse_start();
    chk("t1_busy_armed", d_busy, 1);
    send_frame(4, 16, 0, 1, 0);
    chk("t1_writes", wr_cnt - wr0, 8);
    chk("t1_frame_done", fd_cnt - fd0, 1);
    chk("t1_busy_after", d_busy, 0);
    chk("t1_ovf", d_ovf, 0);
    chk("t1_q_empty", exp_q.size(), 0);
    chk("dec1_writes", wr1_cnt - w10, 16);
    chk("dec1_last_addr", last_addr1, 15);
    chk("dec1_ovf", d1_ovf, 1);

    // Start issued mid-frame: must wait for the next VSYNC high-then-low.
    fd0 = fd_cnt; wr0 = wr_cnt;
    VSYNC = 1'b0; tick();
    m_y = 0;
    drive_line(16, 0, 0);
    pulse_start();
    chk("dec1_ovf_cleared", d1_ovf, 0);
    drive_line(16, 0, 0);
    chk("t2_no_early_wr", wr_cnt - wr0, 0);
    VSYNC = 1'b1; tick(); tick();
    send_frame(4, 16, 1, 1, 0);
    chk("t2_writes", wr_cnt - wr0, 8);
    chk("t2_frame_done", fd_cnt - fd0, 1);

    // Odd first line: trailing byte discarded, following lines stay byte-aligned.
    wr0 = wr_cnt;
    pulse_start();
    send_frame(4, 15, 1, 1, 0);
    chk("t3_writes", wr_cnt - wr0, 8);

    // Six lines into a four-line frame: extra lines ignored without overflow.
    wr0 = wr_cnt;
    pulse_start();
    send_frame(6, 16, 1, 1, 0);
    chk("t4_writes", wr_cnt - wr0, 8);
    chk("t4_ovf", d_ovf, 0);

    // Continuous capture; second start while busy is ignored; drop continuous in frame 3.
    fd0 = fd_cnt; wr0 = wr_cnt;
    continuous = 1'b1;
    pulse_start();
    send_frame(4, 16, 1, 1, 0);
    chk("t5_fd1", fd_cnt - fd0, 1);
    chk("t5_busy1", d_busy, 1);
    pulse_start();
    send_frame(4, 16, 0, 1, 0);
    chk("t5_fd2", fd_cnt - fd0, 2);
    chk("t5_busy2", d_busy, 1);
    send_frame(4, 16, 1, 1, 1);
    chk("t5_fd3", fd_cnt - fd0, 3);
    chk("t5_busy3", d_busy, 0);
    chk("t5_writes", wr_cnt - wr0, 24);

    // Reset while a write is on the RAM port.
    pulse_start();
    m_y = 0; m_addr = 0;
    VSYNC = 1'b0; tick(); tick();
    HREF = 1'b1;
    for (int i = 0; i < 6; i++) begin
      datos = (i % 2 == 0) ? tbl_b1[0] : tbl_b2[0];
      if (i == 1) exp_q.push_back({tbl_px[0], AW'(0)});
      if (i == 5) exp_q.push_back({tbl_px[0], AW'(1)});
      tick();
    end
    chk("t6_regw_pre", d_regw, 1);
    @(negedge PCLK); #2;
    rst = 1'b0;
    #1;
    chk("t6_regw_rst", d_regw, 0);
    chk("t6_busy_rst", d_busy, 0);
    chk("t6_addr_rst", d_addr, 0);
    HREF = 1'b0; datos = 8'h00;
    tick(); tick();
    VSYNC = 1'b1;
    rst = 1'b1;
    repeat (3) tick();
    wr0 = wr_cnt; fd0 = fd_cnt;
    send_frame(4, 16, 0, 0, 0);
    chk("t6_no_writes", wr_cnt - wr0, 0);
    chk("t6_no_fd", fd_cnt - fd0, 0);
    chk("t6_idle", d_busy, 0);
    chk("final_q_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
